// File: rtl/mdu_sched.sv
// MDU sequencing controller: owns HI/LO, models mult/div latency with a
// countdown and raises the ID-stage stall while an operation is in flight.
module mdu_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        d_uses_mdu,
  output logic        start,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] ph_q, ph_d, pl_q, pl_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        dz_q, dz_d;

  logic        accept, is_mul, is_div, sgn;
  logic [63:0] a64, b64, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, dvsr, uq, ur, quo, rem;

  assign busy      = (state_q == BUSY);
  assign accept    = op_valid & ~flush & ~busy;
  assign is_mul    = (op == OP_MULT) | (op == OP_MULTU);
  assign is_div    = (op == OP_DIV)  | (op == OP_DIVU);
  assign sgn       = (op == OP_MULT) | (op == OP_DIV);
  assign start     = accept & (is_mul | is_div);
  assign stall_req = d_uses_mdu & (start | busy);
  assign hi        = hi_q;
  assign lo        = lo_q;

  assign mf_data = (op == OP_MFHI) ? hi_q :
                   (op == OP_MFLO) ? lo_q : 32'd0;

  assign a64  = sgn ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
  assign b64  = sgn ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
  assign prod = a64 * b64;

  // Magnitude divide then re-sign: truncates toward zero and makes
  // 0x80000000 / -1 wrap to 0x80000000 with zero remainder.
  assign neg_a = sgn & rs_val[31];
  assign neg_b = sgn & rt_val[31];
  assign mag_a = neg_a ? 32'd0 - rs_val : rs_val;
  assign mag_b = neg_b ? 32'd0 - rt_val : rt_val;
  assign dvsr  = (rt_val == 32'd0) ? 32'd1 : mag_b;
  assign uq    = mag_a / dvsr;
  assign ur    = mag_a % dvsr;
  assign quo   = (neg_a ^ neg_b) ? 32'd0 - uq : uq;
  assign rem   = neg_a ? 32'd0 - ur : ur;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_mul: begin
              {ph_d, pl_d} = prod;
              dz_d    = 1'b0;
              cnt_d   = MC;
              state_d = BUSY;
            end
            is_div: begin
              ph_d    = rem;
              pl_d    = quo;
              dz_d    = (rt_val == 32'd0);
              cnt_d   = DC;
              state_d = BUSY;
            end
            (op == OP_MTHI): hi_d = rs_val;
            (op == OP_MTLO): lo_d = rs_val;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (!dz_q) begin
            hi_d = ph_q;
            lo_d = pl_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ph_q    <= 32'd0;
      pl_q    <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Scoreboard bench for mdu_sched: commits are checked by a monitor
// against expectations queued when each mult/div is issued.
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        flush = 1'b0;
  logic        d_uses_mdu = 1'b0;
  logic        start, busy, stall_req;
  logic [31:0] hi, lo, mf_data;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  logic prev_busy = 1'b0;

  mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .d_uses_mdu(d_uses_mdu), .start(start), .busy(busy),
    .stall_req(stall_req), .hi(hi), .lo(lo), .mf_data(mf_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL commit_unexpected: hi %h lo %h with empty queue", hi, lo);
        end else begin
          e = exp_q.pop_front();
          chk("commit_hi", hi, e.hi);
          chk("commit_lo", lo, e.lo);
        end
      end
      prev_busy = busy;
    end
  end

  // Issue one op; counts busy cycles, optionally pulses flush/reset
  // at a given busy-cycle index (-1 = never).
  task automatic run_op(input string name, input logic [3:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic fl, input logic d,
                        input logic exp_start, input int exp_n,
                        input int fl_at, input int rst_at);
    int n = 0;
    int stalls = 0;
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    flush = fl; d_uses_mdu = d;
    @(negedge clk);
    chk({name, "_start"}, 32'(start), 32'(exp_start));
    chk({name, "_stall0"}, 32'(stall_req), 32'(d & exp_start));
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0; flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      flush = (i == fl_at);
      reset = (i == rst_at);
      @(negedge clk);
      if (!busy) break;
      n++;
      if (stall_req) stalls++;
    end
    flush = 1'b0;
    reset = 1'b0;
    d_uses_mdu = 1'b0;
    chk({name, "_busy_cycles"}, 32'(n), 32'(exp_n));
    if (d) chk({name, "_stall_cycles"}, 32'(stalls), 32'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);

    exp_q.push_back('{32'hFFFFFFFF, 32'hFFFFFFFE});
    run_op("mult", 4'd1, 32'hFFFFFFFF, 32'd2, 0, 0, 1, 5, -1, -1);
    exp_q.push_back('{32'h00000001, 32'hFFFFFFFE});
    run_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 0, 0, 1, 5, -1, -1);
    exp_q.push_back('{32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 0, 0, 1, 10, -1, -1);
    exp_q.push_back('{32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("divu0", 4'd4, 32'd7, 32'd0, 0, 0, 1, 10, -1, -1);

    exp_q.push_back('{32'd0, 32'd12});
    run_op("mult_stall", 4'd1, 32'd3, 32'd4, 0, 1, 1, 5, -1, -1);
    @(posedge clk); #1;
    op_valid = 1'b1; op = 4'd8;
    @(negedge clk);
    chk("mflo_data", mf_data, 32'd12);
    @(posedge clk); #1;
    op = 4'd7;
    @(negedge clk);
    chk("mfhi_data", mf_data, 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0;

    run_op("mthi_fl", 4'd5, 32'h12345678, 32'd0, 1, 0, 0, 0, -1, -1);
    chk("mthi_fl_hi", hi, 32'd0);
    run_op("mthi", 4'd5, 32'h12345678, 32'd0, 0, 0, 0, 0, -1, -1);
    chk("mthi_hi", hi, 32'h12345678);
    run_op("mtlo", 4'd6, 32'hCAFEF00D, 32'd0, 0, 0, 0, 0, -1, -1);
    chk("mtlo_lo", lo, 32'hCAFEF00D);

    exp_q.push_back('{32'd2, 32'd14});
    run_op("div_flush", 4'd3, 32'd100, 32'd7, 0, 0, 1, 10, 2, -1);

    run_op("div_rst", 4'd3, 32'd50, 32'd5, 0, 0, 1, 4, -1, 3);
    chk("div_rst_hi", hi, 32'd0);
    chk("div_rst_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    chk("div_rst_late_hi", hi, 32'd0);
    chk("div_rst_late_lo", lo, 32'd0);

    exp_q.push_back('{32'd0, 32'h80000000});
    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1, 10, -1, -1);

    run_op("op12", 4'd12, 32'hDEADBEEF, 32'd1, 0, 0, 0, 0, -1, -1);
    chk("op12_hi", hi, 32'd0);
    chk("op12_lo", lo, 32'h80000000);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multiply/divide sequencing controller for the five-stage pipeline. It sits beside the EX stage, accepts MDU instructions (mult/multu/div/divu/mthi/mtlo/mfhi/mflo), owns the HI/LO registers and models multi-cycle latency with a countdown. It produces the stall request consumed by the ID-stage hazard logic, and honours the exception/interrupt flush (Req) so that a flushed instruction never starts an operation.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset
- op_valid  in  1  EX-stage instruction is an MDU op
- op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none
- rs_val  in  32  forwarded rs operand in EX
- rt_val  in  32  forwarded rt operand in EX
- flush  in  1  Req from MEM; suppresses any accept this cycle
- d_uses_mdu  in  1  instruction in ID is any MDU op
- start  out  1  combinational: a mult/div is accepted this cycle
- busy  out  1  registered: operation in flight
- stall_req  out  1  d_uses_mdu & (start | busy)
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- mf_data  out  32  op==7 ? hi : op==8 ? lo : 0 (combinational)

## Operation
- States: IDLE (cnt==0), BUSY (cnt!=0); busy = (cnt!=0). cnt is 4 bits.
- Accept condition: op_valid & !flush & !busy. start = accept & op in {1..4}.
- mult (signed) / multu (unsigned): 64-bit product of rs_val, rt_val latched into shadow {ph, pl}; cnt <= MULT_CYCLES.
- div (signed) / divu (unsigned): pl <= quotient, ph <= remainder (signed: truncate toward zero, remainder sign follows dividend); cnt <= DIV_CYCLES.
- Divide by zero: operation still runs full DIV_CYCLES with busy asserted; HI/LO left unchanged at completion.
- Signed div 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- BUSY: cnt decrements each edge; on the edge where cnt goes 1->0, hi <= ph, lo <= pl (unless div-by-zero flag).
- mthi/mtlo: on accept, hi <= rs_val or lo <= rs_val at the next edge; no busy.
- mfhi/mflo: pure read via mf_data; reads committed hi/lo (never shadow).
- MDU op presented while busy: ignored (hazard logic guarantees it is stalled in ID, so this must not occur; no state change if it does).
- flush during BUSY: in-flight operation continues to completion (its instruction is already past EX).
- flush in the accept cycle: no start, no mthi/mtlo write, cnt unchanged.

## Timing
- Reset: hi=0, lo=0, cnt=0, busy=0, shadow=0, div-by-zero flag=0; start/stall_req follow inputs combinationally (0 when op_valid=0).
- Accept sampled at edge E0 (end of cycle k). busy high cycles k+1 .. k+N (N = MULT_CYCLES or DIV_CYCLES); new hi/lo visible and busy low from cycle k+N+1.
- stall_req high in cycle k (via start) and cycles k+1..k+N whenever d_uses_mdu; a following mfhi in ID issues in cycle k+N+1 and reads the new value.
- mthi/mtlo: value visible on hi/lo in cycle k+1.
- Reset asserted mid-operation: aborts; all state to reset values next edge, no HI/LO commit.
- Back-to-back: a new op may be accepted in cycle k+N+1 (first non-busy cycle).

## Test plan
- Reset, then mult rs=0xFFFFFFFF rt=2 -> busy cycles 1-5 after start, then hi=0xFFFFFFFF lo=0xFFFFFFFE; multu same operands -> hi=0x00000001 lo=0xFFFFFFFE.
- div rs=-7 (0xFFFFFFF9) rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu rs=7 rt=0 -> busy 10 cycles, hi/lo unchanged.
- mult accepted with d_uses_mdu=1 (mflo in ID) -> stall_req high for 6 cycles (start + 5 busy), mf_data on following mflo = new lo.
- mthi rs=0x12345678 with flush=1 -> hi unchanged, start=0; repeat with flush=0 -> hi=0x12345678 next cycle, busy stays 0.
- div in flight, flush pulses at cycle 3 -> still completes at cycle 10 with correct hi/lo; reset at cycle 4 of a second div -> busy=0, hi=lo=0 next cycle, no later commit.
- Signed div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; op=12 with op_valid=1 -> treated as none, no state change.
